// File: rtl/shift_pkg.sv
// Shared constants for the universal shift register: mode and fill encodings plus FSM states.
package shift_pkg;

    localparam logic [1:0] HOLD = 2'b00;
    localparam logic [1:0] SHDN = 2'b01;
    localparam logic [1:0] SHUP = 2'b10;
    localparam logic [1:0] LOAD = 2'b11;

    localparam logic [1:0] FILL_SER  = 2'b00;
    localparam logic [1:0] FILL_ZERO = 2'b01;
    localparam logic [1:0] FILL_ROT  = 2'b10;
    localparam logic [1:0] FILL_ARI  = 2'b11;

    typedef enum logic {
        StIdle,
        StRun
    } state_e;

    function automatic logic is_shift(input logic [1:0] mode);
        return (mode == SHDN) || (mode == SHUP);
    endfunction

endpackage

// File: rtl/shift_step.sv
// One application of the mode/fill step function; pure combinational, shared by idle and run paths.
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] q,
    input  logic [1:0]       mode,
    input  logic [1:0]       fill_sel,
    input  logic             sr,
    input  logic             sl,
    input  logic [WIDTH-1:0] pdata,
    output logic [WIDTH-1:0] q_next
);

    logic dn_fill;
    logic up_fill;

    always_comb begin
        dn_fill = 1'b0;
        unique case (fill_sel)
            FILL_SER:  dn_fill = sr;
            FILL_ZERO: dn_fill = 1'b0;
            FILL_ROT:  dn_fill = q[0];
            FILL_ARI:  dn_fill = q[WIDTH-1];
            default:   dn_fill = 1'b0;
        endcase
    end

    // Arithmetic fill on an up-shift is a plain zero fill.
    always_comb begin
        up_fill = 1'b0;
        unique case (fill_sel)
            FILL_SER:  up_fill = sl;
            FILL_ZERO: up_fill = 1'b0;
            FILL_ROT:  up_fill = q[WIDTH-1];
            FILL_ARI:  up_fill = 1'b0;
            default:   up_fill = 1'b0;
        endcase
    end

    always_comb begin
        q_next = q;
        unique case (mode)
            HOLD:    q_next = q;
            SHDN:    q_next = {dn_fill, q[WIDTH-1:1]};
            SHUP:    q_next = {q[WIDTH-2:0], up_fill};
            LOAD:    q_next = pdata;
            default: q_next = q;
        endcase
    end

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register with legacy S-mode stepping and a multi-cycle shift-by-N command.
module shift_reg_univ
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AMT_W = 6
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [1:0]       S,
    input  logic [1:0]       fill,
    input  logic [WIDTH-1:0] PData,
    input  logic             SR,
    input  logic             SL,
    input  logic             start,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] Q,
    output logic             sout_lo,
    output logic             sout_hi,
    output logic             busy,
    output logic             done
);

    if (WIDTH < 4) begin : g_width_check
        $error("shift_reg_univ: WIDTH must be at least 4");
    end
    if ((64'd1 << AMT_W) <= 64'(WIDTH)) begin : g_amt_check
        $error("shift_reg_univ: AMT_W too narrow for WIDTH");
    end

    state_e           state_q, state_d;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       mode_q, mode_d;
    logic [1:0]       fill_q, fill_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] q_q, q_d;

    logic [1:0]       step_mode;
    logic [1:0]       step_fill;
    logic [WIDTH-1:0] step_q;

    // While running, the latched command drives the step and live S/fill are ignored.
    assign step_mode = (state_q == StRun) ? mode_q : S;
    assign step_fill = (state_q == StRun) ? fill_q : fill;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .q        (q_q),
        .mode     (step_mode),
        .fill_sel (step_fill),
        .sr       (SR),
        .sl       (SL),
        .pdata    (PData),
        .q_next   (step_q)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        fill_d  = fill_q;
        done_d  = 1'b0;
        q_d     = q_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (is_shift(S) && (amt != '0)) begin
                        mode_d  = S;
                        fill_d  = fill;
                        cnt_d   = amt;
                        state_d = StRun;
                    end else begin
                        // Degenerate command: hold or load once, then acknowledge.
                        if (S == LOAD) begin
                            q_d = PData;
                        end
                        done_d = 1'b1;
                    end
                end else begin
                    q_d = step_q;
                end
            end
            StRun: begin
                q_d   = step_q;
                cnt_d = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            mode_q  <= HOLD;
            fill_q  <= FILL_SER;
            done_q  <= 1'b0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            fill_q  <= fill_d;
            done_q  <= done_d;
            q_q     <= q_d;
        end
    end

    assign Q       = q_q;
    assign sout_lo = q_q[0];
    assign sout_hi = q_q[WIDTH-1];
    assign busy    = (state_q == StRun);
    assign done    = done_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed self-checking bench for shift_reg_univ at WIDTH=32, AMT_W=6.
module tb_shift_reg_univ;
    import shift_pkg::*;

    logic        clk;
    logic        clear;
    logic [1:0]  S;
    logic [1:0]  fill;
    logic [31:0] PData;
    logic        SR;
    logic        SL;
    logic        start;
    logic [5:0]  amt;
    logic [31:0] Q;
    logic        sout_lo;
    logic        sout_hi;
    logic        busy;
    logic        done;

    int tests;
    int fails;

    shift_reg_univ #(
        .WIDTH (32),
        .AMT_W (6)
    ) dut (
        .clk     (clk),
        .clear   (clear),
        .S       (S),
        .fill    (fill),
        .PData   (PData),
        .SR      (SR),
        .SL      (SL),
        .start   (start),
        .amt     (amt),
        .Q       (Q),
        .sout_lo (sout_lo),
        .sout_hi (sout_hi),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] v);
        start = 1'b0;
        S     = LOAD;
        PData = v;
        tick();
        S = HOLD;
    endtask

    task automatic launch(input logic [1:0] s, input logic [1:0] f, input logic [5:0] n);
        S     = s;
        fill  = f;
        amt   = n;
        start = 1'b1;
        tick();
        start = 1'b0;
        S     = HOLD;
    endtask

    task automatic wait_done(input int budget, output int edges, output bit got, output bit overlap);
        edges   = 0;
        got     = 1'b0;
        overlap = 1'b0;
        while (!got && edges < budget) begin
            tick();
            edges++;
            if (done && busy) overlap = 1'b1;
            if (done) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        clear = 1'b0;
        #2;
        tests++;
        if (Q !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_init: Q=%h busy=%b done=%b, required Q=00000000 busy=0 done=0",
                     Q, busy, done);
        end
        clear = 1'b1;
        load(32'hA5A5A5A5);
        tests++;
        if (Q !== 32'hA5A5A5A5) begin
            fails++;
            $display("FAIL reset_preload: Q=%h, required a5a5a5a5", Q);
        end
        #3;
        clear = 1'b0;
        #1;
        tests++;
        if (Q !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_async: Q=%h busy=%b done=%b, required Q=00000000 busy=0 done=0",
                     Q, busy, done);
        end
        #1;
        clear = 1'b1;
    endtask

    task automatic test_abort();
        bit saw_done;
        load(32'h0F0F0F0F);
        launch(SHDN, FILL_ZERO, 6'd10);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL abort_busy: busy=%b, required 1", busy);
        end
        tick();
        tick();
        tick();
        #2;
        clear = 1'b0;
        #1;
        tests++;
        if (Q !== 32'h0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL abort_clear: Q=%h busy=%b, required Q=00000000 busy=0", Q, busy);
        end
        #1;
        clear = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) saw_done = 1'b1;
        end
        tests++;
        if (saw_done) begin
            fails++;
            $display("FAIL abort_nodone: done or busy seen after abort, required neither");
        end
    endtask

    task automatic test_legacy();
        load(32'h80000001);
        S    = SHDN;
        fill = FILL_SER;
        SR   = 1'b1;
        tick();
        tests++;
        if (Q !== 32'hC0000000 || done !== 1'b0) begin
            fails++;
            $display("FAIL legacy_down: Q=%h done=%b, required c0000000 done=0", Q, done);
        end
        S  = SHUP;
        SL = 1'b0;
        tick();
        S = HOLD;
        tests++;
        if (Q !== 32'h80000000 || sout_hi !== 1'b1 || sout_lo !== 1'b0) begin
            fails++;
            $display("FAIL legacy_up: Q=%h hi=%b lo=%b, required 80000000 hi=1 lo=0",
                     Q, sout_hi, sout_lo);
        end
        tick();
        tests++;
        if (Q !== 32'h80000000) begin
            fails++;
            $display("FAIL legacy_hold: Q=%h, required 80000000", Q);
        end
    endtask

    task automatic rot_cmd(input logic [5:0] n);
        int edges;
        bit got;
        bit ovl;
        load(32'h12345678);
        launch(SHUP, FILL_ROT, n);
        tests++;
        if (busy !== 1'b1 || Q !== 32'h12345678) begin
            fails++;
            $display("FAIL rot%0d_launch: busy=%b Q=%h, required busy=1 Q=12345678", n, busy, Q);
        end
        wait_done(int'(n) + 5, edges, got, ovl);
        tests++;
        if (!got || edges != int'(n) || ovl) begin
            fails++;
            $display("FAIL rot%0d_timing: done=%b edges=%0d overlap=%b, required done at edge %0d",
                     n, got, edges, ovl, n);
        end
        tests++;
        if (Q !== 32'h23456781 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rot%0d_result: Q=%h busy=%b, required 23456781 busy=0", n, Q, busy);
        end
        tick();
        tests++;
        if (done !== 1'b0 || Q !== 32'h23456781) begin
            fails++;
            $display("FAIL rot%0d_pulse: done=%b Q=%h, required done=0 Q=23456781", n, done, Q);
        end
    endtask

    task automatic test_rotate();
        rot_cmd(6'd4);
        rot_cmd(6'd36);
    endtask

    task automatic test_arith();
        int edges;
        bit got;
        bit ovl;
        load(32'h80000000);
        launch(SHDN, FILL_ARI, 6'd8);
        wait_done(13, edges, got, ovl);
        tests++;
        if (!got || edges != 8 || Q !== 32'hFF800000) begin
            fails++;
            $display("FAIL arith_ari: done=%b edges=%0d Q=%h, required edges=8 Q=ff800000",
                     got, edges, Q);
        end
        load(32'h80000000);
        launch(SHDN, FILL_ZERO, 6'd8);
        wait_done(13, edges, got, ovl);
        tests++;
        if (!got || edges != 8 || Q !== 32'h00800000) begin
            fails++;
            $display("FAIL arith_zero: done=%b edges=%0d Q=%h, required edges=8 Q=00800000",
                     got, edges, Q);
        end
    endtask

    task automatic test_zero_ignore();
        int edges;
        bit got;
        bit ovl;
        load(32'hDEADBEEF);
        launch(SHDN, FILL_SER, 6'd0);
        tests++;
        if (done !== 1'b1 || busy !== 1'b0 || Q !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL zero_amt: done=%b busy=%b Q=%h, required done=1 busy=0 Q=deadbeef",
                     done, busy, Q);
        end
        tick();
        tests++;
        if (done !== 1'b0 || busy !== 1'b0 || Q !== 32'hDEADBEEF) begin
            fails++;
            $display("FAIL zero_after: done=%b busy=%b Q=%h, required done=0 busy=0 Q=deadbeef",
                     done, busy, Q);
        end
        load(32'h12345678);
        launch(SHUP, FILL_ROT, 6'd4);
        S     = LOAD;
        PData = 32'hFFFFFFFF;
        fill  = FILL_ZERO;
        amt   = 6'd1;
        wait_done(9, edges, got, ovl);
        S = HOLD;
        tests++;
        if (!got || edges != 4 || Q !== 32'h23456781) begin
            fails++;
            $display("FAIL ignore_run: done=%b edges=%0d Q=%h, required edges=4 Q=23456781",
                     got, edges, Q);
        end
    endtask

    task automatic test_serial();
        logic [31:0] q_m;
        load(32'h0);
        launch(SHDN, FILL_SER, 6'd32);
        q_m = 32'h0;
        for (int k = 0; k < 32; k++) begin
            SR = (k % 2 == 0);
            tick();
            q_m = {SR, q_m[31:1]};
            tests++;
            if (sout_lo !== q_m[0] || Q !== q_m) begin
                fails++;
                $display("FAIL serial_step%0d: Q=%h lo=%b, required Q=%h lo=%b",
                         k, Q, sout_lo, q_m, q_m[0]);
            end
        end
        tests++;
        if (Q !== 32'h55555555 || done !== 1'b1 || busy !== 1'b0 || sout_hi !== 1'b0) begin
            fails++;
            $display("FAIL serial_final: Q=%h done=%b busy=%b hi=%b, required 55555555 1 0 0",
                     Q, done, busy, sout_hi);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        S     = HOLD;
        fill  = FILL_SER;
        PData = 32'h0;
        SR    = 1'b0;
        SL    = 1'b0;
        start = 1'b0;
        amt   = 6'd0;
        clear = 1'b0;
        #1;
        test_reset();
        test_abort();
        test_legacy();
        test_rotate();
        test_arith();
        test_zero_ignore();
        test_serial();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
